// File: rtl/pwm_engine_scheduler.sv
// rtl/pwm_engine_scheduler.sv - round-robin scheduler time-sharing one pattern PWM engine
// Optional feature macro: PWM_SCHED_REPEAT_EN (adds ch_repeat for continuous re-runs).
module pwm_engine_scheduler #(
  parameter int NUM_CHANNELS  = 4,
  parameter int PAT_WIDTH     = 32,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 255
) (
  input  logic                            clk_50M,
  input  logic                            rst,
  input  logic                            cfg_wr_stb,
  input  logic [7:0]                      cfg_wr_ch,
  input  logic [NUM_CHANNELS-1:0]         ch_en,
  input  logic [8*NUM_CHANNELS-1:0]       duty_bus,
  input  logic [16*NUM_CHANNELS-1:0]      dessert_bus,
  input  logic [8*NUM_CHANNELS-1:0]       pnum_bus,
  input  logic [PAT_WIDTH*NUM_CHANNELS-1:0] pat_bus,
  output logic [7:0]                      eng_duty,
  output logic [15:0]                     eng_dessert,
  output logic [7:0]                      eng_pnum,
  output logic [PAT_WIDTH-1:0]            eng_pat,
  output logic                            eng_start,
  output logic                            eng_stop,
  input  logic                            eng_busy,
  input  logic                            eng_valid,
`ifdef PWM_SCHED_REPEAT_EN
  input  logic [NUM_CHANNELS-1:0]         ch_repeat,
`endif
  output logic [NUM_CHANNELS-1:0]         grant,
  output logic [NUM_CHANNELS-1:0]         pending,
  output logic [NUM_CHANNELS-1:0]         ch_done,
  output logic                            sched_busy,
  output logic                            err_timeout
);

  localparam int IDXW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int TW   = $clog2(START_TIMEOUT + 2);
  localparam int GW   = $clog2(GAP_CYCLES + 2);
  localparam logic [TW-1:0] T_LAST   = TW'(START_TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST   = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [7:0]    CH_LIMIT = 8'(NUM_CHANNELS);
  localparam logic [NUM_CHANNELS-1:0] ONE = {{(NUM_CHANNELS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, RUN, GAP} state_t;

  state_t                  state;
  logic [IDXW-1:0]         ptr, gidx, pick_idx, cand;
  logic                    pick_found;
  logic [TW-1:0]           t_cnt;
  logic [GW-1:0]           g_cnt;
  logic                    rerun;
  logic [NUM_CHANNELS-1:0] eligible, set_vec, clr_vec, keep_vec;
  logic                    wr_hit, abort, finish, timeout;

`ifdef PWM_SCHED_REPEAT_EN
  assign keep_vec = ch_repeat & ch_en;
`else
  assign keep_vec = '0;
`endif

  assign eligible = pending & ch_en;
  assign wr_hit   = |(set_vec & grant);
  assign abort    = (state == RUN) && !ch_en[gidx];
  assign finish   = (state == RUN) && ch_en[gidx] && (eng_valid || !eng_busy);
  assign timeout  = (state == WAIT_BUSY) && !eng_busy && (t_cnt == T_LAST);

  always_comb begin
    set_vec = '0;
    if (cfg_wr_stb && (cfg_wr_ch < CH_LIMIT))
      set_vec[cfg_wr_ch[IDXW-1:0]] = 1'b1;
  end

  // A rewrite of the active channel after its snapshot keeps it pending for another run.
  always_comb begin
    clr_vec = '0;
    if (abort || timeout)
      clr_vec = grant;
    else if (finish && !rerun)
      clr_vec = grant & ~keep_vec;
  end

  // Walk downward so the lowest offset from ptr is the final winner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      cand = IDXW'((int'(ptr) + k) % NUM_CHANNELS);
      if (eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst)
      pending <= '0;
    else
      pending <= ch_en & ((pending & ~clr_vec) | set_vec);
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      gidx        <= '0;
      grant       <= '0;
      eng_duty    <= '0;
      eng_dessert <= '0;
      eng_pnum    <= '0;
      eng_pat     <= '0;
      eng_start   <= 1'b0;
      eng_stop    <= 1'b0;
      ch_done     <= '0;
      sched_busy  <= 1'b0;
      err_timeout <= 1'b0;
      t_cnt       <= '0;
      g_cnt       <= '0;
      rerun       <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      eng_stop  <= 1'b0;
      ch_done   <= '0;
      case (state)
        IDLE: if (pick_found) begin
          gidx       <= pick_idx;
          grant      <= ONE << pick_idx;
          ptr        <= IDXW'((int'(pick_idx) + 1) % NUM_CHANNELS);
          sched_busy <= 1'b1;
          state      <= LOAD;
        end
        LOAD: begin
          eng_duty    <= duty_bus[8*gidx +: 8];
          eng_dessert <= dessert_bus[16*gidx +: 16];
          eng_pnum    <= pnum_bus[8*gidx +: 8];
          eng_pat     <= pat_bus[PAT_WIDTH*gidx +: PAT_WIDTH];
          rerun       <= 1'b0;
          state       <= START;
        end
        START: begin
          eng_start <= 1'b1;
          t_cnt     <= '0;
          if (wr_hit) rerun <= 1'b1;
          state     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (wr_hit) rerun <= 1'b1;
          if (eng_busy) begin
            state <= RUN;
          end else if (timeout) begin
            err_timeout <= 1'b1;
            grant       <= '0;
            g_cnt       <= '0;
            state       <= GAP;
          end else begin
            t_cnt <= t_cnt + 1'b1;
          end
        end
        RUN: begin
          if (wr_hit) rerun <= 1'b1;
          if (abort) begin
            eng_stop <= 1'b1;
            grant    <= '0;
            g_cnt    <= '0;
            state    <= GAP;
          end else if (finish) begin
            ch_done <= grant;
            grant   <= '0;
            g_cnt   <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (g_cnt == G_LAST) begin
            sched_busy <= 1'b0;
            state      <= IDLE;
          end else begin
            g_cnt <= g_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_engine_scheduler.sv
// tb/tb_pwm_engine_scheduler.sv - directed and randomized checks of pwm_engine_scheduler
module tb_pwm_engine_scheduler;
  localparam int N  = 4;
  localparam int PW = 32;

  logic              clk_50M = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_wr_stb = 1'b0;
  logic [7:0]        cfg_wr_ch = 8'd0;
  logic [N-1:0]      ch_en = '0;
  logic [8*N-1:0]    duty_bus, pnum_bus;
  logic [16*N-1:0]   dessert_bus;
  logic [PW*N-1:0]   pat_bus;
  logic [7:0]        eng_duty, eng_pnum;
  logic [15:0]       eng_dessert;
  logic [PW-1:0]     eng_pat;
  logic              eng_start, eng_stop;
  logic              eng_busy = 1'b0;
  logic              eng_valid = 1'b0;
  logic [N-1:0]      grant, pending, ch_done;
  logic              sched_busy, err_timeout;

  logic [7:0]  duty[N];
  logic [7:0]  pnum[N];
  logic [15:0] dess[N];
  logic [31:0] pat[N];

  for (genvar i = 0; i < N; i++) begin : g_bus
    assign duty_bus[8*i +: 8]     = duty[i];
    assign pnum_bus[8*i +: 8]     = pnum[i];
    assign dessert_bus[16*i +: 16] = dess[i];
    assign pat_bus[PW*i +: PW]    = pat[i];
  end

  always #10 clk_50M = ~clk_50M;

  pwm_engine_scheduler #(
    .NUM_CHANNELS(N), .PAT_WIDTH(PW), .GAP_CYCLES(16), .START_TIMEOUT(255)
  ) dut (
    .clk_50M(clk_50M), .rst(rst), .cfg_wr_stb(cfg_wr_stb), .cfg_wr_ch(cfg_wr_ch),
    .ch_en(ch_en), .duty_bus(duty_bus), .dessert_bus(dessert_bus), .pnum_bus(pnum_bus),
    .pat_bus(pat_bus), .eng_duty(eng_duty), .eng_dessert(eng_dessert), .eng_pnum(eng_pnum),
    .eng_pat(eng_pat), .eng_start(eng_start), .eng_stop(eng_stop), .eng_busy(eng_busy),
    .eng_valid(eng_valid),
`ifdef PWM_SCHED_REPEAT_EN
    .ch_repeat('0),
`endif
    .grant(grant), .pending(pending), .ch_done(ch_done),
    .sched_busy(sched_busy), .err_timeout(err_timeout)
  );

  int         vec_cnt = 0;
  int         err_cnt = 0;
  logic [3:0] mp = '0;   // reference pending set
  int         mptr = 0;  // reference round-robin pointer

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] elig, input int p);
    for (int k = 0; k < N; k++)
      if (elig[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic randomize_cfg(input int c);
    duty[c] = 8'($urandom);
    dess[c] = 16'($urandom);
    pnum[c] = 8'($urandom);
    pat[c]  = $urandom;
  endtask

  task automatic strobe(input int c);
    cfg_wr_stb = 1'b1;
    cfg_wr_ch  = 8'(c);
    @(negedge clk_50M);
    cfg_wr_stb = 1'b0;
    if (c < N) if (ch_en[c]) mp[c] = 1'b1;
  endtask

  task automatic wait_start(output int g);
    int cyc = 0;
    g = rr_pick(mp & ch_en, mptr);
    if (g < 0) g = 0;
    while (eng_start !== 1'b1 && cyc < 80) begin
      @(negedge clk_50M);
      cyc++;
    end
    chk("start_seen", 64'(eng_start), 64'(1));
    chk("grant", 64'(grant), 64'(4'b0001 << g));
    chk("eng_duty", 64'(eng_duty), 64'(duty[g]));
    chk("eng_dessert", 64'(eng_dessert), 64'(dess[g]));
    chk("eng_pnum", 64'(eng_pnum), 64'(pnum[g]));
    chk("eng_pat", 64'(eng_pat), 64'(pat[g]));
    mptr = (g + 1) % N;
  endtask

  task automatic run_one(input int busy_len, input bit fall, input logic [3:0] wr_mask);
    int g;
    bit rw = 1'b0;
    wait_start(g);
    eng_busy = 1'b1;
    for (int c = 0; c < N; c++)
      if (wr_mask[c]) begin
        randomize_cfg(c);
        strobe(c);
        if (c == g) rw = 1'b1;
      end
    repeat (busy_len) @(negedge clk_50M);
    if (fall) eng_busy = 1'b0;
    else      eng_valid = 1'b1;
    @(negedge clk_50M);
    eng_valid = 1'b0;
    eng_busy  = 1'b0;
    if (!rw) mp[g] = 1'b0;
    chk("ch_done", 64'(ch_done), 64'(4'b0001 << g));
    chk("pending_after_run", 64'(pending), 64'(mp));
    chk("grant_gap", 64'(grant), 64'(0));
    chk("no_stop", 64'(eng_stop), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    for (int c = 0; c < N; c++) randomize_cfg(c);
    repeat (3) @(negedge clk_50M);
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_pending", 64'(pending), 64'(0));
    chk("rst_busy", 64'(sched_busy), 64'(0));
    chk("rst_eng", 64'({eng_duty, eng_pnum, eng_start, eng_stop, err_timeout}), 64'(0));
    rst = 1'b0;
    @(negedge clk_50M);

    // single request on ch1 with exact latency and gap length
    ch_en = 4'b0010;
    strobe(1);
    chk("t1_pending", 64'(pending), 64'(4'b0010));
    chk("t1_grant_k", 64'(grant), 64'(0));
    @(negedge clk_50M);
    chk("t1_grant_k1", 64'(grant), 64'(4'b0010));
    chk("t1_sched_busy", 64'(sched_busy), 64'(1));
    chk("t1_start_early", 64'(eng_start), 64'(0));
    @(negedge clk_50M);
    chk("t1_duty", 64'(eng_duty), 64'(duty[1]));
    chk("t1_pat", 64'(eng_pat), 64'(pat[1]));
    chk("t1_start_k2", 64'(eng_start), 64'(0));
    @(negedge clk_50M);
    chk("t1_start_k3", 64'(eng_start), 64'(1));
    mptr = 2;
    eng_busy = 1'b1;
    @(negedge clk_50M);
    chk("t1_start_once", 64'(eng_start), 64'(0));
    repeat (9) @(negedge clk_50M);
    eng_valid = 1'b1;
    @(negedge clk_50M);
    eng_valid = 1'b0;
    eng_busy  = 1'b0;
    mp = '0;
    chk("t1_done", 64'(ch_done), 64'(4'b0010));
    chk("t1_pending_clr", 64'(pending), 64'(0));
    eng_valid = 1'b1;
    @(negedge clk_50M);
    eng_valid = 1'b0;
    chk("t1_done_once", 64'(ch_done), 64'(0));
    repeat (14) @(negedge clk_50M);
    chk("t1_gap_busy", 64'(sched_busy), 64'(1));
    @(negedge clk_50M);
    chk("t1_gap_end", 64'(sched_busy), 64'(0));

    // out-of-range channel index is ignored
    strobe(7);
    chk("t2_pending", 64'(pending), 64'(0));
    @(negedge clk_50M);
    chk("t2_idle", 64'(sched_busy), 64'(0));

    // fairness: batch 0,2,3 then 0,3 with the pointer at 0
    ch_en = 4'b1111;
    strobe(3);
    run_one(5, 1'b0, 4'b1101);
    run_one(4, 1'b1, 4'b0000);
    run_one(3, 1'b0, 4'b0000);
    run_one(6, 1'b0, 4'b1001);
    run_one(2, 1'b1, 4'b0000);
    run_one(2, 1'b0, 4'b0000);

    // rewrite of ch1 while it runs: runs again with the new snapshot
    strobe(1);
    run_one(5, 1'b0, 4'b0010);
    run_one(5, 1'b1, 4'b0000);

    // abort by disabling the running channel
    strobe(2);
    strobe(0);
    wait_start(g);
    eng_busy = 1'b1;
    repeat (3) @(negedge clk_50M);
    ch_en = 4'b1011;
    mp[2] = 1'b0;
    @(negedge clk_50M);
    chk("t5_stop", 64'(eng_stop), 64'(1));
    chk("t5_no_done", 64'(ch_done), 64'(0));
    chk("t5_pending", 64'(pending), 64'(mp));
    @(negedge clk_50M);
    chk("t5_stop_once", 64'(eng_stop), 64'(0));
    eng_busy = 1'b0;
    ch_en = 4'b1111;
    run_one(4, 1'b0, 4'b0000);

    // start timeout
    strobe(1);
    wait_start(g);
    repeat (254) @(negedge clk_50M);
    chk("t6_err_early", 64'(err_timeout), 64'(0));
    @(negedge clk_50M);
    mp[1] = 1'b0;
    chk("t6_err_set", 64'(err_timeout), 64'(1));
    chk("t6_no_done", 64'(ch_done), 64'(0));
    chk("t6_pending", 64'(pending), 64'(0));
    chk("t6_grant", 64'(grant), 64'(0));
    repeat (20) @(negedge clk_50M);
    chk("t6_idle", 64'(sched_busy), 64'(0));
    chk("t6_sticky", 64'(err_timeout), 64'(1));

    // reset in the middle of a run
    strobe(3);
    wait_start(g);
    eng_busy = 1'b1;
    repeat (4) @(negedge clk_50M);
    rst = 1'b1;
    @(negedge clk_50M);
    rst = 1'b0;
    eng_busy = 1'b0;
    mp = '0;
    mptr = 0;
    chk("t7_grant", 64'(grant), 64'(0));
    chk("t7_pending", 64'(pending), 64'(0));
    chk("t7_flags", 64'({eng_start, eng_stop, sched_busy, err_timeout}), 64'(0));
    chk("t7_eng", 64'({eng_duty, eng_dessert, eng_pnum}), 64'(0));
    chk("t7_pat", 64'(eng_pat), 64'(0));
    repeat (10) @(negedge clk_50M);
    chk("t7_stays_idle", 64'(sched_busy), 64'(0));

    // randomized traffic against the reference model
    for (int it = 0; it < 10; it++) begin
      if (mp == 4'b0000) strobe(int'($urandom_range(0, 3)));
      run_one(int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 12; i++)
      if (mp != 4'b0000) run_one(2, 1'b0, 4'b0000);
    repeat (25) @(negedge clk_50M);
    chk("final_idle", 64'(sched_busy), 64'(0));
    chk("final_pending", 64'(pending), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
